adc_spi_reader: RTL and testbench

- SPI master that reads conversion frames from an external serial ADC (ADCS7476-style: CS-framed, 16-bit frame with 4 leading zeros and 12 data bits).
- Runs back-to-back frames while enabled.
- Presents each extracted sample on a 1-deep valid/ready output stream to downstream logic (filter/FIFO).
- Receiving end of the ADC's serial output; one clock domain.

---
 rtl/adc_spi_reader.sv | 156 +++++++++++++++
 tb/tb_adc_spi_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_reader.sv
// SPI master for a CS-framed serial ADC: runs back-to-back frames while enabled,
// extracts the data field and offers it on a 1-deep valid/ready stream.
module adc_spi_reader #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FRAME_BITS = 16,
    parameter int unsigned LEAD_BITS  = 4,
    parameter int unsigned DATA_BITS  = 12,
    parameter int unsigned QUIET      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    output logic                 sclk,
    output logic                 cs_n,
    input  logic                 miso,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    output logic                 frame_err
);

    localparam int unsigned CNT_MAX = (CLK_DIV > QUIET) ? CLK_DIV : QUIET;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(FRAME_BITS + 1);
    localparam int unsigned DATA_HI = FRAME_BITS - LEAD_BITS - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_QUIET
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  sync1_q, sync2_q;
    logic                  sclk_d, cs_n_d, valid_d, overrun_d, frame_err_d;
    logic [DATA_BITS-1:0]  sample_d;
    logic                  complete;

    // State, counters, synchronizer and all outputs are registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sclk         <= 1'b1;
            cs_n         <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            sync1_q      <= miso;
            sync2_q      <= sync1_q;
            sclk         <= sclk_d;
            cs_n         <= cs_n_d;
            sample       <= sample_d;
            sample_valid <= valid_d;
            overrun      <= overrun_d;
            frame_err    <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        sclk_d      = sclk;
        cs_n_d      = cs_n;
        sample_d    = sample;
        valid_d     = sample_valid;
        overrun_d   = overrun;
        frame_err_d = 1'b0;
        complete    = 1'b0;

        case (state_q)
            S_IDLE: begin
                sclk_d = 1'b1;
                cs_n_d = 1'b1;
                cnt_d  = '0;
                if (enable) begin
                    state_d = S_SETUP;
                    cs_n_d  = 1'b0;
                end
            end
            S_SETUP: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    state_d = S_SHIFT;
                    sclk_d  = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (cnt_q != CNT_W'(CLK_DIV - 1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (!sclk) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Sample late in the high half so the 2-flop delay still sees settled data
                        shift_d = (shift_q << 1) | FRAME_BITS'(sync2_q);
                        if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                            state_d  = S_QUIET;
                            cs_n_d   = 1'b1;
                            sclk_d   = 1'b1;
                            complete = 1'b1;
                        end else begin
                            sclk_d = 1'b0;
                            bit_d  = bit_q + BIT_W'(1);
                        end
                    end
                end
            end
            S_QUIET: begin
                if (cnt_q == CNT_W'(QUIET - 1)) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = S_SETUP;
                        cs_n_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Output stream: a completion overrides a same-cycle transfer
        if (sample_valid && sample_ready) valid_d = 1'b0;
        if (complete) begin
            sample_d    = shift_d[DATA_HI -: DATA_BITS];
            valid_d     = 1'b1;
            frame_err_d = |shift_d[FRAME_BITS-1 -: LEAD_BITS];
            if (sample_valid && !sample_ready) overrun_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader with a behavioural ADC that shifts a 16-bit
// word out MSB first, changing miso on each sclk falling edge.
module tb_adc_spi_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        sample_ready = 1'b0;
    logic        miso = 1'b0;
    logic        sclk, cs_n, sample_valid, overrun, frame_err;
    logic [11:0] sample;

    always #5 clk = ~clk;

    adc_spi_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .miso         (miso),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ADC model: one word per cs_n frame, taken from a queue (zero when empty)
    logic [15:0] word_q[$];
    logic [15:0] cur_word = 16'h0000;
    int          bit_idx = 0;

    always @(negedge cs_n or negedge sclk) begin
        if (cs_n === 1'b0 && sclk === 1'b1) begin
            if (word_q.size() > 0) cur_word = word_q.pop_front();
            else cur_word = 16'h0000;
            bit_idx = 0;
            miso = 1'b0;
        end else if (cs_n === 1'b0 && sclk === 1'b0 && bit_idx < 16) begin
            miso = cur_word[15 - bit_idx];
            bit_idx++;
        end
    end

    // Per-window statistics gathered by observe()
    int          cs_low, sclk_falls, valid_cnt, ferr_cnt, ferr_on_valid, frames;
    logic [11:0] got_sample;

    task automatic observe(input int ncyc, input int drop_at);
        logic prev_sclk, prev_cs;
        cs_low = 0; sclk_falls = 0; valid_cnt = 0; ferr_cnt = 0;
        ferr_on_valid = 0; frames = 0; got_sample = '0;
        prev_sclk = sclk;
        prev_cs = cs_n;
        for (int i = 0; i < ncyc; i++) begin
            if (i == drop_at) enable = 1'b0;
            @(posedge clk); #1;
            if (!cs_n) cs_low++;
            if (prev_cs && !cs_n) frames++;
            if (prev_sclk && !sclk) sclk_falls++;
            if (sample_valid) begin
                if (valid_cnt == 0) got_sample = sample;
                valid_cnt++;
            end
            if (frame_err) begin
                ferr_cnt++;
                if (sample_valid) ferr_on_valid++;
            end
            prev_sclk = sclk;
            prev_cs = cs_n;
        end
    endtask

    task automatic wait_cs(input logic lvl, input string name);
        int n;
        n = 0;
        while (cs_n !== lvl && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(cs_n), 32'(lvl));
    endtask

    typedef struct {
        logic [15:0] word;
        logic [11:0] exp_sample;
        int          exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0ABC, 12'hABC, 0};
        vecs[1] = '{16'h8ABC, 12'hABC, 1};
        vecs[2] = '{16'h0000, 12'h000, 0};
        vecs[3] = '{16'h0FFF, 12'hFFF, 0};
        vecs[4] = '{16'h1555, 12'h555, 1};
        vecs[5] = '{16'hF000, 12'h000, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", 32'(cs_n), 1);
        check("rst_sclk", 32'(sclk), 1);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_sample", 32'(sample), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_cs_n", 32'(cs_n), 1);

        // Single frames with a one-cycle enable pulse
        sample_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            word_q.push_back(vecs[v].word);
            enable = 1'b1;
            observe(180, 1);
            check($sformatf("v%0d_frames", v), 32'(frames), 1);
            check($sformatf("v%0d_cs_low", v), 32'(cs_low), 132);
            check($sformatf("v%0d_sclk_falls", v), 32'(sclk_falls), 16);
            check($sformatf("v%0d_valid_cycles", v), 32'(valid_cnt), 1);
            check($sformatf("v%0d_sample", v), 32'(got_sample), 32'(vecs[v].exp_sample));
            check($sformatf("v%0d_ferr_cycles", v), 32'(ferr_cnt), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_ferr_on_valid", v), 32'(ferr_on_valid), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_overrun", v), 32'(overrun), 0);
            check($sformatf("v%0d_idle_cs", v), 32'(cs_n), 1);
        end

        // Continuous conversions: sample spacing and inter-frame gap
        begin : cont
            int          cyc, n_s, run, n_gap;
            int          t[3];
            int          gaps[2];
            logic [11:0] s[3];
            logic        pcs, seen_low, done;
            cyc = 0; n_s = 0; run = 0; n_gap = 0;
            pcs = 1'b1; seen_low = 1'b0; done = 1'b0;
            for (int k = 0; k < 3; k++) begin t[k] = 0; s[k] = '0; end
            gaps[0] = 0; gaps[1] = 0;
            word_q.push_back(16'h0001);
            word_q.push_back(16'h0FFF);
            word_q.push_back(16'h0800);
            enable = 1'b1;
            while (cyc < 700 && !done) begin
                @(posedge clk); #1;
                cyc++;
                if (cs_n) run++;
                else begin
                    if (pcs && seen_low && n_gap < 2) begin
                        gaps[n_gap] = run;
                        n_gap++;
                    end
                    seen_low = 1'b1;
                    run = 0;
                end
                pcs = cs_n;
                if (sample_valid && n_s < 3) begin
                    t[n_s] = cyc;
                    s[n_s] = sample;
                    n_s++;
                    if (n_s == 3) begin
                        enable = 1'b0;
                        done = 1'b1;
                    end
                end
            end
            check("cont_three_samples", 32'(n_s), 3);
            check("cont_s0", 32'(s[0]), 32'h001);
            check("cont_s1", 32'(s[1]), 32'hFFF);
            check("cont_s2", 32'(s[2]), 32'h800);
            check("cont_period01", 32'(t[1] - t[0]), 140);
            check("cont_period12", 32'(t[2] - t[1]), 140);
            check("cont_gap_count", 32'(n_gap), 2);
            check("cont_gap0", 32'(gaps[0]), 8);
            check("cont_gap1", 32'(gaps[1]), 8);
            observe(30, -1);
            check("cont_stop_frames", 32'(frames), 0);
            check("cont_stop_cs", 32'(cs_n), 1);
        end

        // Backpressure across two frames
        sample_ready = 1'b0;
        word_q.push_back(16'h0123);
        word_q.push_back(16'h0456);
        enable = 1'b1;
        wait_cs(1'b0, "bp_start1");
        wait_cs(1'b1, "bp_end1");
        check("bp_sample1", 32'(sample), 32'h123);
        check("bp_valid1", 32'(sample_valid), 1);
        check("bp_overrun1", 32'(overrun), 0);
        wait_cs(1'b0, "bp_start2");
        wait_cs(1'b1, "bp_end2");
        enable = 1'b0;
        check("bp_sample2", 32'(sample), 32'h456);
        check("bp_valid2", 32'(sample_valid), 1);
        check("bp_overrun2", 32'(overrun), 1);
        sample_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_after_ready", 32'(sample_valid), 0);
        check("bp_overrun_sticky", 32'(overrun), 1);
        repeat (20) @(posedge clk);
        #1;

        // Reset during bit 8, then a clean frame afterwards
        sample_ready = 1'b0;
        word_q.push_back(16'h0777);
        enable = 1'b1;
        wait_cs(1'b0, "rstmid_start");
        repeat (70) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstmid_cs_n", 32'(cs_n), 1);
        check("rstmid_sclk", 32'(sclk), 1);
        check("rstmid_valid", 32'(sample_valid), 0);
        check("rstmid_overrun", 32'(overrun), 0);
        check("rstmid_sample", 32'(sample), 0);
        sample_ready = 1'b1;
        word_q.push_back(16'h0321);
        rst_n = 1'b1;
        observe(180, 1);
        check("rstmid_next_frames", 32'(frames), 1);
        check("rstmid_next_cs_low", 32'(cs_low), 132);
        check("rstmid_next_sample", 32'(got_sample), 32'h321);
        check("rstmid_next_valid", 32'(valid_cnt), 1);

        // Completion on the same cycle as a transfer
        begin : simul
            int drops;
            sample_ready = 1'b0;
            word_q.push_back(16'h0111);
            word_q.push_back(16'h0222);
            enable = 1'b1;
            wait_cs(1'b0, "sim_start1");
            wait_cs(1'b1, "sim_end1");
            check("sim_sample1", 32'(sample), 32'h111);
            check("sim_valid1", 32'(sample_valid), 1);
            wait_cs(1'b0, "sim_start2");
            drops = 0;
            repeat (131) begin
                @(posedge clk); #1;
                if (!sample_valid) drops++;
            end
            check("sim_valid_held", 32'(drops), 0);
            sample_ready = 1'b1;
            enable = 1'b0;
            @(posedge clk); #1;
            check("sim_cs_rose", 32'(cs_n), 1);
            check("sim_valid2", 32'(sample_valid), 1);
            check("sim_sample2", 32'(sample), 32'h222);
            check("sim_overrun", 32'(overrun), 0);
            @(posedge clk); #1;
            check("sim_valid_drop", 32'(sample_valid), 0);
            repeat (20) @(posedge clk);
            #1;
        end

        // Enable dropped during bit 5: the frame still completes, then idle
        sample_ready = 1'b1;
        word_q.push_back(16'h0ABC);
        enable = 1'b1;
        observe(200, 49);
        check("endrop_frames", 32'(frames), 1);
        check("endrop_cs_low", 32'(cs_low), 132);
        check("endrop_sclk_falls", 32'(sclk_falls), 16);
        check("endrop_sample", 32'(got_sample), 32'hABC);
        check("endrop_valid", 32'(valid_cnt), 1);
        check("endrop_idle_cs", 32'(cs_n), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
